// File: rtl/c1541_gcr_encoder.sv
// rtl/c1541_gcr_encoder.sv - builds one 1541 sector image (sync, GCR header, gap, sync, GCR data, tail gap)
// into a GCR byte buffer, reading the 256 data bytes from a one-cycle-latency RAM.
module c1541_gcr_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  track,
    input  logic [4:0]  sector,
    input  logic [7:0]  id1,
    input  logic [7:0]  id2,
    input  logic [7:0]  gap_len,
    input  logic [12:0] gcr_base,
    output logic [7:0]  ram_addr,
    input  logic [7:0]  ram_din,
    output logic [12:0] gcr_addr,
    output logic [7:0]  gcr_dout,
    output logic        gcr_we,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE, S_HSYNC, S_HDR, S_HGAP, S_DSYNC, S_DATA, S_TGAP, S_FIN
    } state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic [6:0]  grp;
    logic [2:0]  sub;
    logic        emit;
    logic [12:0] wr_addr;
    logic [5:0]  trk_q;
    logic [4:0]  sec_q;
    logic [7:0]  id1_q;
    logic [7:0]  id2_q;
    logic [7:0]  gap_q;
    logic [7:0]  dcks;
    logic [31:0] word;

    logic [7:0]  hcks;
    logic [31:0] hdr_word;
    logic [39:0] code;
    logic [7:0]  emit_byte;
    logic [8:0]  k_base;
    logic [8:0]  k_issue;
    logic [8:0]  k_cap;
    logic        issue_is_ram;
    logic        cap_is_ram;
    logic [7:0]  cap_byte;
    logic        last_grp;
    logic        wr_fire;
    logic [7:0]  wr_byte;

    function automatic logic [4:0] gcr5(input logic [3:0] n);
        case (n)
            4'h0: gcr5 = 5'h0A;
            4'h1: gcr5 = 5'h0B;
            4'h2: gcr5 = 5'h12;
            4'h3: gcr5 = 5'h13;
            4'h4: gcr5 = 5'h0E;
            4'h5: gcr5 = 5'h0F;
            4'h6: gcr5 = 5'h16;
            4'h7: gcr5 = 5'h17;
            4'h8: gcr5 = 5'h09;
            4'h9: gcr5 = 5'h19;
            4'hA: gcr5 = 5'h1A;
            4'hB: gcr5 = 5'h1B;
            4'hC: gcr5 = 5'h0D;
            4'hD: gcr5 = 5'h1D;
            4'hE: gcr5 = 5'h1E;
            default: gcr5 = 5'h15;
        endcase
    endfunction

    function automatic logic [39:0] gcr_group(input logic [31:0] w);
        gcr_group = {gcr5(w[31:28]), gcr5(w[27:24]), gcr5(w[23:20]), gcr5(w[19:16]),
                     gcr5(w[15:12]), gcr5(w[11:8]),  gcr5(w[7:4]),   gcr5(w[3:0])};
    endfunction

    // Data stream index k: 0 = block marker, 1..256 = RAM bytes, 257 = checksum, 258..259 = pad.
    always_comb begin
        hcks     = {3'b000, sec_q} ^ {2'b00, trk_q} ^ id2_q ^ id1_q;
        hdr_word = (grp == 7'd0) ? {8'h08, hcks, {3'b000, sec_q}, {2'b00, trk_q}}
                                 : {id2_q, id1_q, 8'h0F, 8'h0F};
        code     = gcr_group(word);
        case (sub)
            3'd0:    emit_byte = code[39:32];
            3'd1:    emit_byte = code[31:24];
            3'd2:    emit_byte = code[23:16];
            3'd3:    emit_byte = code[15:8];
            3'd4:    emit_byte = code[7:0];
            default: emit_byte = 8'h00;
        endcase

        k_base       = {grp, 2'b00};
        k_issue      = k_base + {6'b000000, sub};
        k_cap        = k_base + {6'b000000, sub} - 9'd2;
        issue_is_ram = (k_issue != 9'd0) && (k_issue <= 9'd256);
        cap_is_ram   = (k_cap != 9'd0) && (k_cap <= 9'd256);
        if (k_cap == 9'd0)
            cap_byte = 8'h07;
        else if (cap_is_ram)
            cap_byte = ram_din;
        else if (k_cap == 9'd257)
            cap_byte = dcks;
        else
            cap_byte = 8'h00;

        last_grp = (state == S_HDR) ? (grp == 7'd1) : (grp == 7'd64);

        wr_fire = 1'b0;
        wr_byte = 8'h00;
        case (state)
            S_HSYNC, S_DSYNC: begin
                wr_fire = 1'b1;
                wr_byte = 8'hFF;
            end
            S_HGAP, S_TGAP: begin
                wr_fire = 1'b1;
                wr_byte = 8'h55;
            end
            S_HDR, S_DATA: begin
                wr_fire = emit;
                wr_byte = emit_byte;
            end
            default: begin
                wr_fire = 1'b0;
                wr_byte = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= 8'd0;
            grp      <= 7'd0;
            sub      <= 3'd0;
            emit     <= 1'b0;
            wr_addr  <= 13'd0;
            trk_q    <= 6'd0;
            sec_q    <= 5'd0;
            id1_q    <= 8'd0;
            id2_q    <= 8'd0;
            gap_q    <= 8'd0;
            dcks     <= 8'd0;
            word     <= 32'd0;
            ram_addr <= 8'd0;
            gcr_addr <= 13'd0;
            gcr_dout <= 8'd0;
            gcr_we   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            gcr_we <= wr_fire;
            done   <= 1'b0;
            if (wr_fire) begin
                gcr_dout <= wr_byte;
                gcr_addr <= wr_addr;
                wr_addr  <= wr_addr + 13'd1;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        trk_q   <= track;
                        sec_q   <= sector;
                        id1_q   <= id1;
                        id2_q   <= id2;
                        gap_q   <= gap_len;
                        wr_addr <= gcr_base;
                        cnt     <= 8'd0;
                        busy    <= 1'b1;
                        state   <= S_HSYNC;
                    end
                end

                S_HSYNC: begin
                    if (cnt == 8'd4) begin
                        cnt   <= 8'd0;
                        grp   <= 7'd0;
                        sub   <= 3'd0;
                        emit  <= 1'b0;
                        state <= S_HDR;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end

                S_HDR, S_DATA: begin
                    if (emit) begin
                        if (sub == 3'd4) begin
                            sub  <= 3'd0;
                            emit <= 1'b0;
                            if (!last_grp)
                                grp <= grp + 7'd1;
                            else if (state == S_HDR)
                                state <= S_HGAP;
                            else
                                state <= (gap_q == 8'd0) ? S_FIN : S_TGAP;
                            cnt <= 8'd0;
                        end else begin
                            sub <= sub + 3'd1;
                        end
                    end else if (state == S_HDR) begin
                        word <= hdr_word;
                        emit <= 1'b1;
                    end else begin
                        // Gather: issue RAM reads on sub 0..3, capture bytes two cycles later on sub 2..5.
                        if (sub <= 3'd3 && issue_is_ram)
                            ram_addr <= {grp[5:0], 2'b00} + {5'b00000, sub} - 8'd1;
                        if (sub >= 3'd2) begin
                            word <= {word[23:0], cap_byte};
                            if (cap_is_ram)
                                dcks <= dcks ^ ram_din;
                        end
                        if (sub == 3'd5) begin
                            sub  <= 3'd0;
                            emit <= 1'b1;
                        end else begin
                            sub <= sub + 3'd1;
                        end
                    end
                end

                S_HGAP: begin
                    if (cnt == 8'd8) begin
                        cnt   <= 8'd0;
                        state <= S_DSYNC;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end

                S_DSYNC: begin
                    if (cnt == 8'd4) begin
                        cnt   <= 8'd0;
                        grp   <= 7'd0;
                        sub   <= 3'd0;
                        emit  <= 1'b0;
                        dcks  <= 8'd0;
                        state <= S_DATA;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end

                S_TGAP: begin
                    if (cnt == gap_q - 8'd1) begin
                        cnt   <= 8'd0;
                        state <= S_FIN;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end

                S_FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
